uart_tx_fifo: RTL and testbench

- Byte queue that sits directly upstream of the Uart8 transmitter and feeds its tx interface (txEn/txStart/txIn, observing txBusy/txDone).
- Host logic pushes bytes at any rate. The block buffers them and drives the level-sensitive txStart handshake one byte at a time, so bytes go out back-to-back without the host tracking UART timing.
- Flags overflow and a stalled transmitter.

---
 rtl/uart_tx_fifo_pkg.sv | 15 +
 rtl/uart_tx_fifo_sync_fifo.sv | 80 ++++++++
 rtl/uart_tx_fifo.sv | 153 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit queue.
//   BYTE_W     : width of one UART data byte
//   txState_t  : handshake states used by the top level to feed Uart8
package uart_tx_fifo_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } txState_t;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// sync_fifo: single-clock circular byte queue.
//   clk, rstN     : rising-edge clock, synchronous active-low reset
//   wrEn, wrData  : push request; ignored while full or while flushing
//   rdEn          : pop request; ignored while empty
//   flush         : discard everything queued (read pointer jumps to write pointer)
//   rdData        : current head entry, valid whenever empty is low
//   full, empty   : occupancy flags derived from count
//   count         : number of entries held
module sync_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int  DEPTH  = 16,
    parameter int  WIDTH  = BYTE_W,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             wrEn,
    input  logic [WIDTH-1:0] wrData,
    input  logic             rdEn,
    input  logic             flush,
    output logic [WIDTH-1:0] rdData,
    output logic             full,
    output logic             empty,
    output logic [ADDR_W:0]  count
);

    localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wrPtr;
    logic [ADDR_W-1:0] rdPtr;
    logic              pushOk;
    logic              popOk;

    // Full is judged on the count before any pop in the same cycle, so a push
    // against a full queue is always refused even if the head leaves now.
    // A flush swallows a concurrent push rather than storing it.
    assign full   = (count == COUNT_FULL);
    assign empty  = (count == '0);
    assign pushOk = wrEn && !full && !flush;
    assign popOk  = rdEn && !empty;
    assign rdData = mem[rdPtr];

    // Storage needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem[wrPtr] <= wrData;
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    // A flush empties the queue by moving the read pointer onto the write
    // pointer; a pop in that cycle still hands its head entry to the reader.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushOk) begin
                wrPtr <= wrPtr + ADDR_W'(1);
            end
            if (flush) begin
                rdPtr <= wrPtr;
                count <= '0;
            end else begin
                if (popOk) begin
                    rdPtr <= rdPtr + ADDR_W'(1);
                end
                case ({pushOk, popOk})
                    2'b10:   count <= count + (ADDR_W + 1)'(1);
                    2'b01:   count <= count - (ADDR_W + 1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte queue feeding a Uart8 transmitter one byte at a time.
//   clk, rstN          : rising-edge clock, synchronous active-low reset
//   wrEn, wrData       : host push interface
//   flush              : drop queued bytes (the byte already handed to the UART is kept)
//   full, empty, level : queue occupancy, excluding the in-flight byte
//   overflow           : sticky, a push was refused because the queue was full
//   timeoutErr         : sticky, the UART never went busy after txStart was raised
//   errClr             : clears both sticky flags (a new error in the same cycle wins)
//   txEn, txStart, txIn: drive the Uart8 transmit side
//   txBusy, txDone     : status returned by the Uart8 transmitter
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int  DEPTH         = 16,
    parameter int  START_TIMEOUT = 4096,
    localparam int ADDR_W        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              wrEn,
    input  logic [BYTE_W-1:0] wrData,
    input  logic              flush,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              timeoutErr,
    input  logic              errClr,
    output logic              txEn,
    output logic              txStart,
    output logic [BYTE_W-1:0] txIn,
    input  logic              txBusy,
    input  logic              txDone
);

    localparam int                TIMER_W    = $clog2(START_TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(START_TIMEOUT - 1);

    txState_t          state;
    logic [TIMER_W-1:0] startTimer;
    logic [BYTE_W-1:0] txInReg;
    logic              txStartReg;
    logic              txEnReg;
    logic              overflowReg;
    logic              timeoutReg;
    logic [BYTE_W-1:0] headData;
    logic              popReq;
    logic              overflowSet;
    logic              timeoutSet;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BYTE_W)
    ) queue (
        .clk    (clk),
        .rstN   (rstN),
        .wrEn   (wrEn),
        .wrData (wrData),
        .rdEn   (popReq),
        .flush  (flush),
        .rdData (headData),
        .full   (full),
        .empty  (empty),
        .count  (level)
    );

    // The head is taken only from IDLE, which guarantees a single byte in
    // flight. A full-queue push counts as an overflow unless a flush is
    // discarding it anyway. The timeout fires on the last permitted START
    // cycle when the UART still has not gone busy.
    assign popReq      = (state == IDLE) && !empty;
    assign overflowSet = wrEn && full && !flush;
    assign timeoutSet  = (state == START) && !txBusy && (startTimer == TIMER_LAST);

    assign txEn    = txEnReg;
    assign txStart = txStartReg;
    assign txIn    = txInReg;

    // Handshake sequencer. txIn is loaded on the pop and txStart is raised one
    // cycle later from inside START, so the UART never samples txStart while
    // txIn is still changing. GAP forces at least one low txStart cycle
    // between frames because Uart8 triggers on the level, not an edge.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state      <= IDLE;
            startTimer <= '0;
            txInReg    <= '0;
            txStartReg <= 1'b0;
            txEnReg    <= 1'b0;
        end else begin
            txEnReg <= 1'b1;
            case (state)
                IDLE: begin
                    txStartReg <= 1'b0;
                    if (popReq) begin
                        txInReg    <= headData;
                        startTimer <= '0;
                        state      <= START;
                    end
                end
                START: begin
                    if (txBusy) begin
                        txStartReg <= 1'b0;
                        state      <= WAIT_DONE;
                    end else if (timeoutSet) begin
                        txStartReg <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        txStartReg <= 1'b1;
                        startTimer <= startTimer + TIMER_W'(1);
                    end
                end
                WAIT_DONE: begin
                    txStartReg <= 1'b0;
                    if (txDone || !txBusy) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    txStartReg <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    txStartReg <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // Sticky error flags; a fresh error outranks a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            overflowReg <= 1'b0;
            timeoutReg  <= 1'b0;
        end else begin
            if (overflowSet) begin
                overflowReg <= 1'b1;
            end else if (errClr) begin
                overflowReg <= 1'b0;
            end
            if (timeoutSet) begin
                timeoutReg <= 1'b1;
            end else if (errClr) begin
                timeoutReg <= 1'b0;
            end
        end
    end

    assign overflow   = overflowReg;
    assign timeoutErr = timeoutReg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo. A small UART stub stands in for Uart8: it
// accepts a byte when it sees txStart high while idle, stays busy for a random
// frame length, then pulses txDone. A queue-based model predicts the FIFO
// contents, flags and handshake outputs and is compared against the DUT every
// cycle; directed sequences pin a few hand-computed values.
module tb_uart_tx_fifo;

    localparam int DEPTH         = 16;
    localparam int START_TIMEOUT = 4096;

    logic       clk    = 1'b0;
    logic       rstN   = 1'b0;
    logic       wrEn   = 1'b0;
    logic [7:0] wrData = 8'h00;
    logic       flush  = 1'b0;
    logic       errClr = 1'b0;
    logic       txBusy = 1'b0;
    logic       txDone = 1'b0;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;
    logic       timeoutErr;
    logic       txEn;
    logic       txStart;
    logic [7:0] txIn;

    int assertCount = 0;
    int failCount   = 0;
    int cyc         = 0;

    uart_tx_fifo #(
        .DEPTH         (DEPTH),
        .START_TIMEOUT (START_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rstN       (rstN),
        .wrEn       (wrEn),
        .wrData     (wrData),
        .flush      (flush),
        .full       (full),
        .empty      (empty),
        .level      (level),
        .overflow   (overflow),
        .timeoutErr (timeoutErr),
        .errClr     (errClr),
        .txEn       (txEn),
        .txStart    (txStart),
        .txIn       (txIn),
        .txBusy     (txBusy),
        .txDone     (txDone)
    );

    // Free-running clock and an edge counter used for latency measurements.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Stand-in for the Uart8 transmitter. While stalled it never goes busy,
    // which is how the start timeout is provoked.
    bit         stall = 1'b0;
    int         frameLeft = 0;
    logic [7:0] rxQ[$];

    always @(posedge clk) begin
        txDone <= 1'b0;
        if (txBusy) begin
            if (frameLeft <= 1) begin
                txBusy <= 1'b0;
                txDone <= 1'b1;
            end
            frameLeft <= frameLeft - 1;
        end else if (txStart && !stall) begin
            txBusy    <= 1'b1;
            frameLeft <= int'($urandom_range(3, 12));
            rxQ.push_back(txIn);
        end
    end

    // Behavioural model: the queue is a plain SV queue and the transmit side
    // is tracked as launch / sending / settle phases of the current byte.
    typedef enum {M_IDLE, M_LAUNCH, M_SENDING, M_SETTLE} phase_t;

    logic [7:0] mq[$];
    logic [7:0] sentQ[$];
    phase_t     mPhase = M_IDLE;
    int         mAge = 0;
    bit         mTxStart = 1'b0;
    bit         mTxEn = 1'b0;
    bit         mOverflow = 1'b0;
    bit         mTimeout = 1'b0;
    bit         modelValid = 1'b0;
    logic [7:0] mTxIn = 8'h00;

    always @(posedge clk) begin
        if (!rstN) begin
            mq.delete();
            mPhase     = M_IDLE;
            mAge       = 0;
            mTxStart   = 1'b0;
            mTxIn      = 8'h00;
            mTxEn      = 1'b0;
            mOverflow  = 1'b0;
            mTimeout   = 1'b0;
            modelValid = 1'b1;
        end else begin
            int preCount;
            bit ovSet;
            bit toSet;
            bit popNow;
            preCount = mq.size();
            ovSet    = wrEn && !flush && (preCount == DEPTH);
            toSet    = 1'b0;
            popNow   = 1'b0;
            mTxEn    = 1'b1;
            mTxStart = 1'b0;
            case (mPhase)
                M_IDLE: begin
                    if (preCount > 0) begin
                        popNow = 1'b1;
                        mTxIn  = mq[0];
                        mAge   = 0;
                        mPhase = M_LAUNCH;
                    end
                end
                M_LAUNCH: begin
                    if (txBusy) begin
                        sentQ.push_back(mTxIn);
                        mPhase = M_SENDING;
                    end else if (mAge == START_TIMEOUT - 1) begin
                        toSet  = 1'b1;
                        mPhase = M_IDLE;
                    end else begin
                        mAge     = mAge + 1;
                        mTxStart = 1'b1;
                    end
                end
                M_SENDING: begin
                    if (txDone || !txBusy) begin
                        mPhase = M_SETTLE;
                    end
                end
                default: mPhase = M_IDLE;
            endcase
            if (popNow) begin
                void'(mq.pop_front());
            end
            if (flush) begin
                mq.delete();
            end else if (wrEn && preCount != DEPTH) begin
                mq.push_back(wrData);
            end
            mOverflow = ovSet || (mOverflow && !errClr);
            mTimeout  = toSet || (mTimeout && !errClr);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Every-cycle comparison of all DUT outputs against the model, taken on
    // the falling edge so both sides have settled after the rising edge.
    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("level", 32'(level), 32'(mq.size()));
            checkOutput("empty", 32'(empty), 32'(mq.size() == 0));
            checkOutput("full", 32'(full), 32'(mq.size() == DEPTH));
            checkOutput("overflow", 32'(overflow), 32'(mOverflow));
            checkOutput("timeoutErr", 32'(timeoutErr), 32'(mTimeout));
            checkOutput("txEn", 32'(txEn), 32'(mTxEn));
            checkOutput("txStart", 32'(txStart), 32'(mTxStart));
            checkOutput("txIn", 32'(txIn), 32'(mTxIn));
        end
    end

    // Drive one cycle of host inputs, let one rising edge pass, release them.
    task automatic applyStimulus(input logic we, input logic [7:0] d, input logic fl, input logic ec);
        wrEn   = we;
        wrData = d;
        flush  = fl;
        errClr = ec;
        @(negedge clk);
        wrEn   = 1'b0;
        flush  = 1'b0;
        errClr = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitBusy(input int bound);
        int n = 0;
        while (!txBusy && n < bound) begin
            @(negedge clk);
            n++;
        end
        assertCount++;
        if (!txBusy) begin
            failCount++;
            $display("[TB] FAIL waitBusy: txBusy=%0b after %0d cycles, required 1", txBusy, bound);
        end
    endtask

    task automatic waitQuiet(input int bound);
        int n = 0;
        int quiet = 0;
        while (quiet < 4 && n < bound) begin
            @(negedge clk);
            n++;
            quiet = (empty && !txBusy && !txStart) ? quiet + 1 : 0;
        end
        assertCount++;
        if (quiet < 4) begin
            failCount++;
            $display("[TB] FAIL waitQuiet: transmitter still active after %0d cycles, required idle", bound);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0;
        int rx0;
        int n;

        $display("[TB] reset values");
        tick(2);
        checkOutput("rst level", 32'(level), 0);
        checkOutput("rst empty", 32'(empty), 1);
        checkOutput("rst full", 32'(full), 0);
        checkOutput("rst txStart", 32'(txStart), 0);
        checkOutput("rst txIn", 32'(txIn), 0);
        checkOutput("rst txEn", 32'(txEn), 0);
        rstN = 1'b1;
        tick(1);
        checkOutput("txEn after reset", 32'(txEn), 1);

        $display("[TB] single byte latency");
        applyStimulus(1'b1, 8'h45, 1'b0, 1'b0);
        checkOutput("level after push", 32'(level), 1);
        tick(1);
        checkOutput("txStart at pop", 32'(txStart), 0);
        checkOutput("level at pop", 32'(level), 0);
        tick(1);
        checkOutput("txStart two cycles", 32'(txStart), 1);
        checkOutput("txIn two cycles", 32'(txIn), 32'h45);
        waitQuiet(200);
        checkOutput("rx 0x45", 32'(rxQ[rxQ.size() - 1]), 32'h45);

        $display("[TB] back-to-back bytes");
        rx0 = rxQ.size();
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h02, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h03, 1'b0, 1'b0);
        checkOutput("level peak", 32'(level), 2);
        waitQuiet(300);
        checkOutput("b2b count", 32'(rxQ.size() - rx0), 3);
        checkOutput("b2b rx0", 32'(rxQ[rx0]), 32'h01);
        checkOutput("b2b rx1", 32'(rxQ[rx0 + 1]), 32'h02);
        checkOutput("b2b rx2", 32'(rxQ[rx0 + 2]), 32'h03);

        $display("[TB] stalled transmitter");
        stall = 1'b1;
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b0);
        c0 = cyc;
        for (int i = 1; i < 17; i++) begin
            applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        end
        checkOutput("full after 17", 32'(full), 1);
        checkOutput("level after 17", 32'(level), 16);
        checkOutput("overflow before 18", 32'(overflow), 0);
        applyStimulus(1'b1, 8'h21, 1'b0, 1'b0);
        checkOutput("overflow after 18", 32'(overflow), 1);
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h23, 1'b0, 1'b0);
        n = 0;
        while (!timeoutErr && n < START_TIMEOUT + 500) begin
            tick(1);
            n++;
        end
        checkOutput("timeout latency", 32'(cyc - c0), 32'(START_TIMEOUT + 1));
        checkOutput("timeoutErr set", 32'(timeoutErr), 1);
        tick(1);
        checkOutput("next byte popped", 32'(level), 15);
        checkOutput("next byte txIn", 32'(txIn), 32'h11);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("errClr overflow", 32'(overflow), 0);
        checkOutput("errClr timeoutErr", 32'(timeoutErr), 0);
        applyStimulus(1'b1, 8'h30, 1'b0, 1'b0);
        checkOutput("refilled full", 32'(full), 1);
        applyStimulus(1'b1, 8'h31, 1'b0, 1'b1);
        checkOutput("set beats clear", 32'(overflow), 1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("flush level", 32'(level), 0);
        checkOutput("clear after set", 32'(overflow), 0);
        stall = 1'b0;
        waitQuiet(200);

        $display("[TB] flush during frame");
        rx0 = rxQ.size();
        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hBB, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hCC, 1'b0, 1'b0);
        waitBusy(50);
        tick(2);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("flush level 0", 32'(level), 0);
        checkOutput("flush empty", 32'(empty), 1);
        waitQuiet(200);
        checkOutput("flush rx count", 32'(rxQ.size() - rx0), 1);
        checkOutput("flush rx AA", 32'(rxQ[rx0]), 32'hAA);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h78, 1'b0, 1'b0);
        waitBusy(50);
        tick(1);
        rstN = 1'b0;
        tick(1);
        rstN = 1'b1;
        checkOutput("mid rst txStart", 32'(txStart), 0);
        checkOutput("mid rst level", 32'(level), 0);
        checkOutput("mid rst overflow", 32'(overflow), 0);
        checkOutput("mid rst timeoutErr", 32'(timeoutErr), 0);
        waitQuiet(100);
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
        waitQuiet(200);
        checkOutput("rx 0x5A", 32'(rxQ[rxQ.size() - 1]), 32'h5A);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom % 3) == 0, 8'($urandom), ($urandom % 64) == 0, ($urandom % 32) == 0);
        end
        waitQuiet(600);

        checkOutput("rx byte count", 32'(rxQ.size()), 32'(sentQ.size()));
        for (int i = 0; i < rxQ.size() && i < sentQ.size(); i++) begin
            checkOutput("rx byte", 32'(rxQ[i]), 32'(sentQ[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
